// File: rtl/instr_encoder.sv
// Symbolic-instruction to MIPS word encoder with byte-address tagging,
// a 2-entry output FIFO and a saturating count of rejected requests.
module instr_encoder #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          ERR_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_kind,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [25:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [3:0] K_ADDU = 4'd0;
  localparam logic [3:0] K_SUBU = 4'd1;
  localparam logic [3:0] K_ORI  = 4'd2;
  localparam logic [3:0] K_LUI  = 4'd3;
  localparam logic [3:0] K_LW   = 4'd4;
  localparam logic [3:0] K_SW   = 4'd5;
  localparam logic [3:0] K_J    = 4'd6;
  localparam logic [3:0] K_JAL  = 4'd7;
  localparam logic [3:0] K_JR   = 4'd8;
  localparam logic [3:0] K_BEQ  = 4'd9;

  logic [1:0]       count_reg, count_next;
  logic             wrPtr_reg, rdPtr_reg;
  logic [31:0]      pc_reg;
  logic             err_reg;
  logic [ERR_W-1:0] errCnt_reg;
  logic [63:0]      fifoMem [2];

  logic [31:0] encWord;
  logic        encLegal;
  logic        accept, push, pop;
  logic        immHiZero, beqFits;

  assign immHiZero = ~|in_imm[25:16];
  // beq offset fits in signed 16 bits only if bits 25..15 are a pure sign extension
  assign beqFits   = (&in_imm[25:15]) || ~|in_imm[25:15];

  always_comb begin
    encWord  = 32'h0;
    encLegal = 1'b1;
    case (in_kind)
      K_ADDU: encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h21};
      K_SUBU: encWord = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h23};
      K_ORI: begin
        encWord  = {6'h0D, in_rs, in_rt, in_imm[15:0]};
        encLegal = immHiZero;
      end
      K_LUI: begin
        encWord  = {6'h0F, 5'h00, in_rt, in_imm[15:0]};
        encLegal = immHiZero;
      end
      K_LW: begin
        encWord  = {6'h23, in_rs, in_rt, in_imm[15:0]};
        encLegal = immHiZero;
      end
      K_SW: begin
        encWord  = {6'h2B, in_rs, in_rt, in_imm[15:0]};
        encLegal = immHiZero;
      end
      K_J:    encWord = {6'h02, in_imm};
      K_JAL:  encWord = {6'h03, in_imm};
      K_JR:   encWord = {6'h00, in_rs, 15'h0000, 6'h08};
      K_BEQ: begin
        encWord  = {6'h04, in_rs, in_rt, in_imm[15:0]};
        encLegal = beqFits;
      end
      default: encLegal = 1'b0;
    endcase
  end

  // Readiness uses the pre-pop count, so a full FIFO rejects even while draining
  assign in_ready = (count_reg < 2'd2) && !clear;
  assign accept   = in_valid && in_ready;
  assign push     = accept && encLegal;
  assign pop      = out_valid && out_ready;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg  <= 2'd0;
      wrPtr_reg  <= 1'b0;
      rdPtr_reg  <= 1'b0;
      pc_reg     <= PC_BASE;
      err_reg    <= 1'b0;
      errCnt_reg <= '0;
    end else if (clear) begin
      count_reg <= 2'd0;
      wrPtr_reg <= 1'b0;
      rdPtr_reg <= 1'b0;
      pc_reg    <= PC_BASE;
      err_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      err_reg   <= accept && !encLegal;
      if (push) begin
        wrPtr_reg <= ~wrPtr_reg;
        pc_reg    <= pc_reg + 32'd4;
      end
      if (pop)
        rdPtr_reg <= ~rdPtr_reg;
      if (accept && !encLegal && !(&errCnt_reg))
        errCnt_reg <= errCnt_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (push && (wrPtr_reg == 1'(gi)))
          fifoMem[gi] <= {encWord, pc_reg};
      end
    end
  endgenerate

  assign out_valid = (count_reg != 2'd0);
  assign out_instr = out_valid ? fifoMem[rdPtr_reg][63:32] : 32'h0;
  assign out_addr  = out_valid ? fifoMem[rdPtr_reg][31:0]  : PC_BASE;
  assign err       = err_reg;
  assign err_cnt   = errCnt_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed program-loader scenarios plus random traffic,
// all checked against a queue-based behavioural model of the encoder.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_kind = 4'd0;
  logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
  logic [25:0] in_imm = 26'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr, out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  instr_encoder #(.PC_BASE(BASE), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field positions with plain arithmetic
  function automatic void modelEnc(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [4:0] rd, input logic [25:0] imm,
                                   output bit ok, output logic [31:0] w);
    longint s;
    longint unsigned rsF, rtF, rdF, i16, immU, acc;
    rsF = longint'(rs) * 2097152;
    rtF = longint'(rt) * 65536;
    rdF = longint'(rd) * 2048;
    immU = longint'(imm);
    i16 = immU % 65536;
    ok = 1'b1;
    acc = 0;
    case (k)
      4'd0: acc = rsF + rtF + rdF + 33;
      4'd1: acc = rsF + rtF + rdF + 35;
      4'd2: begin ok = (immU < 65536); acc = 13 * 67108864 + rsF + rtF + i16; end
      4'd3: begin ok = (immU < 65536); acc = 15 * 67108864 + rtF + i16; end
      4'd4: begin ok = (immU < 65536); acc = 35 * 67108864 + rsF + rtF + i16; end
      4'd5: begin ok = (immU < 65536); acc = 43 * 67108864 + rsF + rtF + i16; end
      4'd6: acc = 2 * 67108864 + immU;
      4'd7: acc = 3 * 67108864 + immU;
      4'd8: acc = rsF + 8;
      4'd9: begin
        s = (immU >= 33554432) ? longint'(immU) - 67108864 : longint'(immU);
        ok = (s >= -32768) && (s <= 32767);
        acc = 4 * 67108864 + rsF + rtF + i16;
      end
      default: ok = 1'b0;
    endcase
    w = acc[31:0];
  endfunction

  // Behavioural model state
  logic [63:0] modelQ[$];
  logic [31:0] modelPc = BASE;
  logic        modelErr = 1'b0;
  int          modelErrCnt = 0;
  bit          modelOn = 0;
  logic [63:0] popLog[$];

  always @(posedge clk) begin
    bit ok, acc;
    logic [31:0] w;
    modelEnc(in_kind, in_rs, in_rt, in_rd, in_imm, ok, w);
    if (!reset) begin
      modelQ.delete(); modelPc = BASE; modelErr = 1'b0; modelErrCnt = 0;
    end else if (clear) begin
      modelQ.delete(); modelPc = BASE; modelErr = 1'b0;
    end else begin
      acc = in_valid && (modelQ.size() < 2);
      modelErr = acc && !ok;
      if (acc && !ok && modelErrCnt < 255) modelErrCnt++;
      if (modelQ.size() > 0 && out_ready) begin
        popLog.push_back(modelQ[0]);
        void'(modelQ.pop_front());
      end
      if (acc && ok) begin
        modelQ.push_back({w, modelPc});
        modelPc = modelPc + 32'd4;
      end
    end
    modelOn = 1;
  end

  always @(negedge clk) begin
    if (modelOn) begin
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, modelQ.size() != 0});
      if (modelQ.size() != 0) begin
        chk("m_out_instr", out_instr, modelQ[0][63:32]);
        chk("m_out_addr", out_addr, modelQ[0][31:0]);
      end
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (modelQ.size() < 2) && !clear});
      chk("m_err", {31'd0, err}, {31'd0, modelErr});
      chk("m_err_cnt", {24'd0, err_cnt}, modelErrCnt);
    end
  end

  task automatic sendReq(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [25:0] imm);
    bit done;
    done = 0;
    @(negedge clk); #1;
    in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
    for (int t = 0; t < 40 && !done; t++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk); #1;
      end
    end
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idleN(input int n);
    @(negedge clk); #1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic clearPulse();
    @(negedge clk); #1;
    in_valid = 1'b0; clear = 1'b1;
    @(negedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic checkLog(input string name, input int idx, input logic [31:0] ins, input logic [31:0] ad);
    if (idx >= popLog.size()) begin
      compared++; mismatched++;
      $display("FAIL %s: only %0d words emitted, need index %0d", name, popLog.size(), idx);
    end else begin
      chk({name, "_instr"}, popLog[idx][63:32], ins);
      chk({name, "_addr"}, popLog[idx][31:0], ad);
    end
  endtask

  initial begin
    int base;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, BASE);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    #1 reset = 1'b1;

    // Single addu: visible at the head one cycle after acceptance
    sendReq(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    @(negedge clk);
    chk("addu_valid", {31'd0, out_valid}, 32'd1);
    chk("addu_instr", out_instr, 32'h00221821);
    chk("addu_addr", out_addr, 32'h00003000);
    #1 in_valid = 1'b0;

    clearPulse();
    base = popLog.size();
    sendReq(4'd2, 5'd0, 5'd1, 5'd0, 26'h1234);
    sendReq(4'd3, 5'd0, 5'd1, 5'd0, 26'hFFFF);
    sendReq(4'd5, 5'd0, 5'd2, 5'd0, 26'd4);
    idleN(4);
    checkLog("ori", base, 32'h34011234, 32'h3000);
    checkLog("lui", base + 1, 32'h3C01FFFF, 32'h3004);
    checkLog("sw", base + 2, 32'hAC020004, 32'h3008);

    clearPulse();
    base = popLog.size();
    sendReq(4'd7, 5'd0, 5'd0, 5'd0, 26'hC00);
    sendReq(4'd8, 5'd31, 5'd0, 5'd0, 26'd0);
    sendReq(4'd9, 5'd1, 5'd2, 5'd0, 26'h3FFFFFF);
    idleN(4);
    checkLog("jal", base, 32'h0C000C00, 32'h3000);
    checkLog("jr", base + 1, 32'h03E00008, 32'h3004);
    checkLog("beq", base + 2, 32'h1022FFFF, 32'h3008);

    // Backpressure: fill, hold, then drain while a third push waits
    clearPulse();
    base = popLog.size();
    out_ready = 1'b0;
    sendReq(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    sendReq(4'd1, 5'd4, 5'd5, 5'd6, 26'd0);
    @(negedge clk); #1;
    in_valid = 1'b1; in_kind = 4'd2; in_rs = 5'd0; in_rt = 5'd1; in_imm = 26'h1234;
    #1;
    chk("bp_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("bp_head", out_instr, 32'h00221821);
    @(negedge clk);
    chk("bp_head_hold", out_instr, 32'h00221821);
    #1 out_ready = 1'b1;
    #1 chk("bp_full_pop_rdy", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("bp_after_pop_rdy", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    idleN(4);
    checkLog("bp0", base, 32'h00221821, 32'h3000);
    checkLog("bp1", base + 1, 32'h00853023, 32'h3004);
    checkLog("bp2", base + 2, 32'h34011234, 32'h3008);

    // Illegal requests: accepted, counted, never emitted, no address advance
    clearPulse();
    base = popLog.size();
    sendReq(4'd12, 5'd1, 5'd1, 5'd1, 26'd0);
    @(negedge clk);
    chk("ill_err_pulse", {31'd0, err}, 32'd1);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("ill_err_single", {31'd0, err}, 32'd0);
    sendReq(4'd2, 5'd0, 5'd1, 5'd0, 26'h10000);
    sendReq(4'd9, 5'd1, 5'd2, 5'd0, 26'h0008000);
    idleN(2);
    chk("ill_err_cnt", {24'd0, err_cnt}, 32'd3);
    chk("ill_no_words", popLog.size() - base, 32'd0);
    sendReq(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    idleN(3);
    checkLog("ill_next", base, 32'h00221821, 32'h3000);

    for (int i = 0; i < 260; i++) sendReq(4'd13, 5'd0, 5'd0, 5'd0, 26'd0);
    idleN(2);
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'hFF);

    // Clear with two words queued
    out_ready = 1'b0;
    sendReq(4'd0, 5'd1, 5'd2, 5'd3, 26'd0);
    sendReq(4'd1, 5'd4, 5'd5, 5'd6, 26'd0);
    @(negedge clk); #1;
    in_valid = 1'b0; clear = 1'b1;
    #1 chk("clr_rdy_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk); #1;
    clear = 1'b0;
    #1;
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_in_ready", {31'd0, in_ready}, 32'd1);
    chk("clr_err_cnt", {24'd0, err_cnt}, 32'hFF);
    out_ready = 1'b1;
    sendReq(4'd0, 5'd7, 5'd8, 5'd9, 26'd0);
    @(negedge clk);
    chk("clr_next_addr", out_addr, 32'h3000);
    #1 in_valid = 1'b0;

    // Reset wins over clear
    @(negedge clk); #1;
    reset = 1'b0; clear = 1'b1;
    @(negedge clk); #1;
    reset = 1'b1; clear = 1'b0;
    #1;
    chk("rc_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rc_out_addr", out_addr, BASE);
    chk("rc_err_cnt", {24'd0, err_cnt}, 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      int r;
      @(negedge clk); #1;
      reset = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_kind = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      r = $urandom_range(0, 3);
      case (r)
        0: in_imm = 26'($urandom);
        1: in_imm = 26'($urandom_range(0, 65535));
        2: in_imm = 26'h3FF8000 | 26'($urandom_range(0, 32767));
        default: in_imm = 26'($urandom_range(0, 32767));
      endcase
    end
    @(negedge clk); #1;
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the pipeline's main control decoder: converts a symbolic instruction (kind code plus register/immediate fields) into a 32-bit MIPS word for the supported subset (addu, subu, ori, lui, lw, sw, j, jal, jr, beq).
- Emits each word with its instruction-memory byte address on a valid/ready stream.
- Used as the program loader feeding IM in pipeline testbenches.
- Holds output in a 2-entry FIFO and counts rejected requests.

Parameters:
- PC_BASE, 32'h0000_3000, byte address assigned to the first emitted word after reset or clear.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset.
- clear  input  1  synchronous flush; restarts the address stream.
- in_valid  input  1  request valid.
- in_ready  output  1  encoder can accept a request.
- in_kind  input  4  0 addu, 1 subu, 2 ori, 3 lui, 4 lw, 5 sw, 6 j, 7 jal, 8 jr, 9 beq; 10-15 are illegal.
- in_rs  input  5  rs field.
- in_rt  input  5  rt field.
- in_rd  input  5  rd field.
- in_imm  input  26  imm16 in [15:0] for I-types; beq word offset, signed; 26-bit index for j/jal.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head.
- out_instr  output  32  encoded word.
- out_addr  output  32  byte address of out_instr.
- err  output  1  one-cycle pulse on a rejected request.
- err_cnt  output  ERR_W  count of rejected requests, saturating.

Behaviour:
- Reset (reset==0 at an edge): FIFO emptied, out_valid=0, out_instr=0, out_addr=PC_BASE, address counter=PC_BASE, err=0, err_cnt=0. Reset has priority over clear.
- clear==1: FIFO emptied, address counter=PC_BASE, err=0. err_cnt is kept. in_ready is forced 0 while clear is high, so no request is accepted that cycle.
- Handshake:
  - in_ready = (fifo_count<2) && !clear.
  - A request is accepted when in_valid && in_ready at an edge.
  - The head is popped when out_valid && out_ready at an edge.
  - in_ready is computed from the count before any same-cycle pop, so a full FIFO with a simultaneous pop still rejects the push.
- Latency: an accepted legal request is visible at the FIFO head on the next cycle if the FIFO was empty or was popped to empty. Throughput is 1 word per cycle.
- Out-of-order is impossible: the FIFO is strictly in order. out_instr/out_addr hold their value while out_valid && !out_ready.
- Encoding (op|rs|rt|rd|shamt|func):
  - addu: 0|rs|rt|rd|0|0x21
  - subu: 0|rs|rt|rd|0|0x23
  - ori: 0x0D|rs|rt|imm16
  - lui: 0x0F|0|rt|imm16
  - lw: 0x23|rs|rt|imm16
  - sw: 0x2B|rs|rt|imm16
  - beq: 0x04|rs|rt|imm[15:0]
  - j: 0x02|imm26
  - jal: 0x03|imm26
  - jr: 0|rs|0|0|0|0x08
- Unused input fields are ignored; they never leak into the word.
- Legality checks; a request is illegal if any of these holds:
  - kind is 10-15;
  - kind is ori/lui/lw/sw and imm[25:16] != 0;
  - kind is beq and imm[25:15] is not all-equal (offset does not fit in signed 16 bits).
- Illegal request:
  - It is still accepted (the handshake completes), but nothing is enqueued and the address is not advanced.
  - err pulses high the following cycle for exactly one cycle.
  - err_cnt increments, saturating at all-ones.
- Address counter:
  - Each legal accepted request takes the current counter as its out_addr.
  - The counter then advances by 4, wrapping modulo 2^32.
- FIFO: 2 entries, 64 bits each (instr+addr), with wrap-around read/write pointers.

Test Plan:
- Reset, then addu rs=1 rt=2 rd=3 -> next cycle out_valid=1, out_instr=0x00221821, out_addr=0x00003000.
- Back-to-back ori rs=0 rt=1 imm=0x1234; lui rt=1 imm=0xFFFF; sw rs=0 rt=2 imm=4, with out_ready=1 -> 0x34011234@0x3000, 0x3C01FFFF@0x3004, 0xAC020004@0x3008 on consecutive cycles.
- jal imm=0xC00; jr rs=31; beq rs=1 rt=2 imm=0x3FFFFFF (-1) -> 0x0C000C00, 0x03E00008, 0x1022FFFF.
- Backpressure: hold out_ready=0 and push 3 requests -> in_ready drops after 2 accepts; head stays stable; raising out_ready drains both in order. A push with a simultaneous pop while full is rejected (in_ready=0).
- Illegal inputs: kind=12, then ori imm=0x10000, then beq imm=0x0008000 -> three err pulses, err_cnt=3, no words emitted, and the next legal word gets out_addr=0x3000. Force err_cnt to 0xFF -> it stays at 0xFF.
- clear with 2 words queued -> next cycle out_valid=0, in_ready=1, and the next word gets addr 0x3000 with err_cnt unchanged. Asserting reset and clear together -> reset result, err_cnt=0.
